// File: rtl/fast_square_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fast_square_pkg
// Brief    : State codes and default sizing for the fast-square sweep sequencer
// Revision : 1.0  initial release
// ============================================================================
package fast_square_pkg;

  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] SWEEP_RESET = 4'd1;
  localparam logic [3:0] GUARD       = 4'd2;
  localparam logic [3:0] WAIT_LOCK   = 4'd3;
  localparam logic [3:0] RECORD      = 4'd4;
  localparam logic [3:0] STEP        = 4'd5;

  localparam int DEF_NUM_FREQ_STEPS = 37;
  localparam int DEF_RECORD_TICKS   = 35000;
  localparam int DEF_PULSE_TICKS    = 16;
  localparam int DEF_GUARD_TICKS    = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Two-flop synchronizer for a single asynchronous level
// Revision : 1.0  initial release
// ============================================================================
module sync2 (
  input  logic clk64,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk64 or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/fast_square_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fast_square_ctrl
// Brief    : Steps the PLL through a frequency sweep and gates record windows
// Revision : 1.0  initial release
// ============================================================================
module fast_square_ctrl
  import fast_square_pkg::*;
#(
  parameter int NUM_FREQ_STEPS = DEF_NUM_FREQ_STEPS,
  parameter int RECORD_TICKS   = DEF_RECORD_TICKS,
  parameter int PULSE_TICKS    = DEF_PULSE_TICKS,
  parameter int GUARD_TICKS    = DEF_GUARD_TICKS
) (
  input  logic       clk64,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       freq_step_reset_out,
  output logic       freq_step_out,
  output logic       rx_reset,
  output logic       rx_next,
  output logic       rx_record,
  output logic [3:0] debug
);

  // One spare bit keeps the terminal compare value from ever wrapping.
  localparam int TICK_W = $clog2(max3(RECORD_TICKS, PULSE_TICKS, GUARD_TICKS)) + 1;
  localparam int IDX_W  = $clog2(NUM_FREQ_STEPS) + 1;

  localparam logic [TICK_W-1:0] C_TICK_ONE    = TICK_W'(1);
  localparam logic [TICK_W-1:0] C_PULSE_LAST  = TICK_W'(PULSE_TICKS - 1);
  localparam logic [TICK_W-1:0] C_GUARD_LAST  = TICK_W'(GUARD_TICKS - 1);
  localparam logic [TICK_W-1:0] C_RECORD_LAST = TICK_W'(RECORD_TICKS - 1);
  localparam logic [IDX_W-1:0]  C_IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]  C_IDX_LAST    = IDX_W'(NUM_FREQ_STEPS - 1);

  logic [3:0]        r_state;
  logic [TICK_W-1:0] r_tick;
  logic [IDX_W-1:0]  r_step_idx;
  logic              w_lock_s;

  sync2 u_lock_sync (
    .clk64 (clk64),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (w_lock_s)
  );

  always_ff @(posedge clk64 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_step_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= SWEEP_RESET;
          r_tick  <= '0;
        end

        SWEEP_RESET: begin
          r_step_idx <= '0;
          if (r_tick == C_PULSE_LAST) begin
            r_state <= GUARD;
            r_tick  <= '0;
          end else begin
            r_tick <= r_tick + C_TICK_ONE;
          end
        end

        // Lock is deliberately not looked at here: the synthesizer may still
        // report the previous frequency's lock right after a pulse.
        GUARD: begin
          if (r_tick == C_GUARD_LAST) begin
            r_state <= WAIT_LOCK;
            r_tick  <= '0;
          end else begin
            r_tick <= r_tick + C_TICK_ONE;
          end
        end

        WAIT_LOCK: begin
          r_tick <= '0;
          if (w_lock_s) begin
            r_state <= RECORD;
          end
        end

        RECORD: begin
          if (r_tick == C_RECORD_LAST) begin
            r_tick  <= '0;
            r_state <= (r_step_idx == C_IDX_LAST) ? SWEEP_RESET : STEP;
          end else begin
            r_tick <= r_tick + C_TICK_ONE;
          end
        end

        STEP: begin
          if (r_tick == C_PULSE_LAST) begin
            r_state    <= GUARD;
            r_tick     <= '0;
            r_step_idx <= r_step_idx + C_IDX_ONE;
          end else begin
            r_tick <= r_tick + C_TICK_ONE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_tick     <= '0;
          r_step_idx <= '0;
        end
      endcase
    end
  end

  always_comb begin
    freq_step_reset_out = 1'b0;
    rx_reset            = 1'b0;
    freq_step_out       = 1'b0;
    rx_next             = 1'b0;
    rx_record           = 1'b0;
    debug               = r_state;
    case (r_state)
      SWEEP_RESET: begin
        freq_step_reset_out = 1'b1;
        rx_reset            = 1'b1;
      end
      STEP: begin
        freq_step_out = 1'b1;
        rx_next       = (r_tick == '0);
      end
      RECORD: begin
        rx_record = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fast_square_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fast_square_ctrl
// Brief    : Cycle scoreboard for the sweep sequencer (3 steps, short timers)
// Revision : 1.0  initial release
// ============================================================================
module tb_fast_square_ctrl;

  localparam int N_STEPS = 3;
  localparam int REC     = 10;
  localparam int PULSE   = 4;
  localparam int GUARD_T = 5;

  logic       clk64 = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       freq_step_reset_out;
  logic       freq_step_out;
  logic       rx_reset;
  logic       rx_next;
  logic       rx_record;
  logic [3:0] debug;

  typedef struct {
    logic [8:0] exp;
    string      tag;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  fast_square_ctrl #(
    .NUM_FREQ_STEPS (N_STEPS),
    .RECORD_TICKS   (REC),
    .PULSE_TICKS    (PULSE),
    .GUARD_TICKS    (GUARD_T)
  ) dut (
    .clk64               (clk64),
    .rst_n               (rst_n),
    .pll_locked          (pll_locked),
    .freq_step_reset_out (freq_step_reset_out),
    .freq_step_out       (freq_step_out),
    .rx_reset            (rx_reset),
    .rx_next             (rx_next),
    .rx_record           (rx_record),
    .debug               (debug)
  );

  always #5 clk64 = ~clk64;

  function automatic logic [8:0] obs_vec();
    return {debug, freq_step_reset_out, freq_step_out, rx_reset, rx_next, rx_record};
  endfunction

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (debug,srst,step,rxrst,next,rec)", tag, got, exp);
  endtask

  // Expected output vector for a state and the cycle position within it.
  function automatic logic [8:0] exp_vec(input int st, input int pos);
    logic srst, stp, nxt, rec;
    srst = (st == 1);
    stp  = (st == 5);
    nxt  = (st == 5) && (pos == 0);
    rec  = (st == 4);
    return {4'(st), srst, stp, srst, nxt, rec};
  endfunction

  task automatic push_seg(input int st, input int len);
    sb_entry_t e;
    for (int i = 0; i < len; i++) begin
      e.exp = exp_vec(st, i);
      e.tag = $sformatf("st%0d_c%0d", st, i);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_sweep();
    push_seg(1, PULSE);
    for (int s = 0; s < N_STEPS; s++) begin
      push_seg(2, GUARD_T);
      push_seg(3, 1);
      push_seg(4, REC);
      if (s < N_STEPS - 1) push_seg(5, PULSE);
    end
  endtask

  task automatic drain();
    int guard_cnt;
    guard_cnt = 0;
    do begin
      @(negedge clk64);
      #1;
      guard_cnt++;
    end while (sb_q.size() != 0 && guard_cnt < 2000);
    check_eq("drain_timeout", 9'(sb_q.size()), 9'd0);
    sb_q.delete();
  endtask

  always @(negedge clk64) begin
    if (sb_q.size() != 0) begin
      sb_entry_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, obs_vec(), e.exp);
    end
  end

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    repeat (2) @(negedge clk64);
    #1;
    push_seg(0, 3);
    drain();

    // Full sweep with lock held high, followed by the next sweep reset.
    rst_n = 1'b1;
    push_sweep();
    push_seg(1, PULSE);
    drain();

    // Delayed lock: WAIT_LOCK holds until the synchronized lock arrives.
    pll_locked = 1'b0;
    push_seg(2, GUARD_T);
    push_seg(3, 50);
    drain();
    pll_locked = 1'b1;
    push_seg(3, 2);
    push_seg(4, 5);
    drain();

    // Lock drop mid-record and absent through GUARD.
    pll_locked = 1'b0;
    push_seg(4, 5);
    push_seg(5, PULSE);
    push_seg(2, GUARD_T);
    push_seg(3, 3);
    drain();
    pll_locked = 1'b1;
    push_seg(3, 2);
    push_seg(4, 5);
    drain();

    // Reset during the sixth record cycle.
    @(posedge clk64);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", obs_vec(), 9'd0);
    @(negedge clk64);
    #1;
    push_seg(0, 2);
    drain();
    rst_n = 1'b1;
    push_sweep();
    push_seg(1, PULSE);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fast_square_ctrl.md
# fast_square_ctrl

Frequency-sweep sequencer for the fast-square receive path in the USRP standard top level. It steps an external PLL synthesizer through NUM_FREQ_STEPS frequencies and waits for lock at each one. It then opens a fixed-length record window for the fast-square receiver and restarts the sweep after the last step. Its outputs drive the FX2 step/reset pins and the receiver's reset, next and record inputs; its state is exported on a debug nibble.

## Interface
- NUM_FREQ_STEPS, 37: frequencies per sweep (≥1).
- RECORD_TICKS, 35000: clock cycles per record window (≥1).
- PULSE_TICKS, 16: width of the step and sweep-reset pulses (≥1).
- GUARD_TICKS, 64: cycles after a pulse during which pll_locked is ignored (≥1).
- clock  in  1  system clock (clk64).
- reset  in  1  asynchronous, active-low reset.
- pll_locked  in  1  synthesizer lock pin; asynchronous to clock.
- freq_step_reset_out  out  1  returns the synthesizer to its start frequency.
- freq_step_out  out  1  advances the synthesizer one step.
- rx_reset  out  1  resets the fast-square receiver.
- rx_next  out  1  one-cycle "next frequency bin" strobe to the receiver.
- rx_record  out  1  receiver accumulates samples while high.
- debug  out  4  current state encoding.

## Operation
- pll_locked passes through a 2-flop synchronizer to produce lock_s; no other logic samples the raw pin.
- The state machine uses a tick counter and a step index (0..NUM_FREQ_STEPS-1).
- Each state's code and exit rule:
  - IDLE (0): entered while reset is asserted; exits to SWEEP_RESET on the first clock after release.
  - SWEEP_RESET (1): lasts PULSE_TICKS cycles; clears step index to 0; then GUARD.
  - GUARD (2): lasts GUARD_TICKS cycles; lock_s is ignored; then WAIT_LOCK.
  - WAIT_LOCK (3): stays until lock_s=1, with no timeout; then RECORD.
  - RECORD (4): lasts RECORD_TICKS cycles. If step index = NUM_FREQ_STEPS-1 it exits to SWEEP_RESET; otherwise to STEP.
  - STEP (5): lasts PULSE_TICKS cycles; increments the step index on exit; then GUARD.
- Outputs are a Moore decode of the registered state and tick counter:
  - freq_step_reset_out = rx_reset = (state==SWEEP_RESET).
  - freq_step_out = (state==STEP).
  - rx_next = (state==STEP && tick==0).
  - rx_record = (state==RECORD).
  - debug = state.
- pll_locked dropping during RECORD is ignored; the window always runs its full RECORD_TICKS.
- With NUM_FREQ_STEPS=1, STEP never occurs and every RECORD is followed by SWEEP_RESET.
- If reset asserts mid-operation, all state is abandoned and the block is in IDLE immediately. A new sweep starts from SWEEP_RESET.

## Timing
- While reset is asserted: state=IDLE, counters=0, synchronizer=0, and every output is 0.
- Counters are sized with $clog2 of the largest parameter, plus one bit so the terminal value never wraps.
- Exact cycle counts per state:
  - freq_step_reset_out and rx_reset are high for exactly PULSE_TICKS consecutive cycles per sweep.
  - freq_step_out is high for exactly PULSE_TICKS cycles per step.
  - rx_next is high for exactly 1 cycle, coincident with the first cycle of freq_step_out.
  - rx_record is high for exactly RECORD_TICKS cycles.
- Lock latency: if pll_locked is high before edge k, lock_s is high after edge k+1 and rx_record rises after edge k+2. This holds provided GUARD has expired.
- A lock that is already present when GUARD expires gives exactly 1 WAIT_LOCK cycle.
- Per sweep: NUM_FREQ_STEPS record windows, NUM_FREQ_STEPS-1 step pulses, 1 sweep-reset pulse.

## Structure
- Shared package fast_square_pkg holds the state encoding localparams (IDLE..STEP, 4-bit) and the default parameter values.
- One natural sub-module: sync2 (2-flop synchronizer, active-low async reset), used for pll_locked.
- The remaining FSM and counters live in one always block, with a separate output decode.

## Test plan
All scenarios use NUM_FREQ_STEPS=3, RECORD_TICKS=10, PULSE_TICKS=4, GUARD_TICKS=5.
- Reset: hold reset=0 with pll_locked=1 → all outputs 0, debug=0. Release → debug=1 on the next cycle, and freq_step_reset_out and rx_reset are high for 4 cycles.
- Lock held high: run one full sweep → the sequence is:
  - 1 sweep-reset pulse, then 3 rx_record windows of 10 cycles each;
  - 2 freq_step_out pulses of 4 cycles, each with exactly one rx_next cycle;
  - then a sweep-reset pulse again.
- Delayed lock: keep pll_locked=0 for 50 cycles after GUARD → debug holds 3. Raise pll_locked → rx_record rises 3 edges later.
- Lock drop: toggle pll_locked low at cycle 5 of RECORD and low throughout GUARD → the record window still lasts 10 cycles, and no early transition occurs in GUARD.
- Mid-operation reset: assert reset in cycle 6 of RECORD → outputs 0 immediately. After release, a fresh SWEEP_RESET occurs and the step index restarts at 0, giving 3 records before the next sweep reset.
